key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debounce_ch.sv | 80 ++++++++
 rtl/key_debounce.sv | 30 +++
 tb/tb_key_debounce.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM states and the default
// debounce interval.
package key_pkg;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    ARM_DN = 2'd1,
    DOWN   = 2'd2,
    ARM_UP = 2'd3
  } key_state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 500000;

  // The debounced level is high in the settled-pressed state and while a release is being qualified
  function automatic logic is_level(input key_state_t st);
    return (st == DOWN) || (st == ARM_UP);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualification counter, 4-state FSM
// and registered level/press/release outputs.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  // The entry sample counts as the first one, so the last sample arrives at count DB_CYCLES-2
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 2);

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;
  key_state_t    state;

  assign s = ~sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      state <= UP;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      level <= is_level(state);
      press <= is_level(state) & ~level;
      rel   <= ~is_level(state) & level;

      case (state)
        UP: begin
          if (s) begin
            state <= ARM_DN;
            cnt   <= '0;
          end
        end
        ARM_DN: begin
          if (!s) begin
            state <= UP;
          end else if (cnt == LAST) begin
            state <= DOWN;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (!s) begin
            state <= ARM_UP;
            cnt   <= '0;
          end
        end
        ARM_UP: begin
          if (s) begin
            state <= DOWN;
          end else if (cnt == LAST) begin
            state <= UP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: active-low raw keys in, active-high
// debounced level plus single-cycle press/release pulses out.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS    = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .key_raw(KEY[i]),
      .level  (key_level[i]),
      .press  (key_press[i]),
      .rel    (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DB_CYCLES=8, N_KEYS=2: vector table, directed
// corner sequences and random stimulus against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned NK = 2;
  localparam int unsigned DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_level, key_press, key_release;

  always #5 clk = ~clk;

  key_debounce #(
    .N_KEYS   (NK),
    .DB_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: level flips once DB consecutive samples disagree with it; outputs lag one cycle
  logic [NK-1:0] m_d1, m_d2, m_lvl, m_out, m_press, m_rel;
  int unsigned   m_run [NK];

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '1; m_d2 = '1; m_lvl = '0; m_out = '0; m_press = '0; m_rel = '0;
      for (int c = 0; c < NK; c++) m_run[c] = 0;
    end else begin
      m_press = m_lvl & ~m_out;
      m_rel   = ~m_lvl & m_out;
      m_out   = m_lvl;
      for (int c = 0; c < NK; c++) begin
        if (~m_d2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_lvl[c] = ~m_d2[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = KEY;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({key_level, key_press, key_release} !== {m_out, m_press, m_rel}) begin
        errors++;
        $display("FAIL model lvl/press/rel actual=%b/%b/%b required=%b/%b/%b",
                 key_level, key_press, key_release, m_out, m_press, m_rel);
      end
      if ((key_press & key_release) != '0) begin
        errors++;
        $display("FAIL press_and_release_together actual=%b required=00", key_press & key_release);
      end
    end
  end

  typedef struct {
    logic [1:0]  key;
    int unsigned hold;
    logic [1:0]  level;
    int unsigned presses;
    int unsigned releases;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int p0, p1, r0, r1, lowc, hic, np, nr;

    tbl[0] = '{2'b11, 20, 2'b00, 0, 0};
    tbl[1] = '{2'b10,  7, 2'b00, 0, 0};
    tbl[2] = '{2'b11, 20, 2'b00, 0, 0};
    tbl[3] = '{2'b10, 15, 2'b01, 1, 0};
    tbl[4] = '{2'b00, 15, 2'b11, 1, 0};
    tbl[5] = '{2'b01, 15, 2'b10, 0, 1};
    tbl[6] = '{2'b11, 15, 2'b00, 0, 1};
    tbl[7] = '{2'b00, 12, 2'b11, 2, 0};
    tbl[8] = '{2'b11, 10, 2'b11, 0, 0};
    tbl[9] = '{2'b11,  5, 2'b00, 0, 2};

    rst = 1'b1;
    KEY = 2'b11;
    step();
    chk_en = 1'b1;
    check("reset_level", key_level, 0);
    check("reset_pulses", {key_press, key_release}, 0);
    step();
    rst = 1'b0;
    repeat (20) step();

    // Vector table
    foreach (tbl[r]) begin
      KEY = tbl[r].key;
      np = 0;
      nr = 0;
      for (int i = 0; i < int'(tbl[r].hold); i++) begin
        step();
        np += $countones(key_press);
        nr += $countones(key_release);
      end
      check($sformatf("tbl%0d_level", r), key_level, tbl[r].level);
      check($sformatf("tbl%0d_presses", r), np, tbl[r].presses);
      check($sformatf("tbl%0d_releases", r), nr, tbl[r].releases);
    end
    repeat (20) step();

    // Clean press on key 0
    KEY = 2'b10;
    p0 = 0; p1 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      p0 += key_press[0];
      p1 += key_press[1];
      if (i == 10) check("press_level_at10", key_level[0], 0);
      if (i == 11) begin
        check("press_level_at11", key_level[0], 1);
        check("press_pulse_at11", key_press[0], 1);
      end
      if (i == 12) check("press_pulse_at12", key_press[0], 0);
    end
    check("press_count0", p0, 1);
    check("press_count1", p1, 0);

    // Clean release
    KEY = 2'b11;
    r0 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      r0 += key_release[0];
      if (i == 10) check("release_level_at10", key_level[0], 1);
      if (i == 11) begin
        check("release_level_at11", key_level[0], 0);
        check("release_pulse_at11", key_release[0], 1);
      end
    end
    check("release_count0", r0, 1);

    // Release glitch while held
    KEY = 2'b10;
    repeat (20) step();
    KEY = 2'b11;
    np = 0; lowc = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) KEY = 2'b10;
      step();
      np += $countones(key_press) + $countones(key_release);
      lowc += (key_level[0] == 1'b0);
    end
    check("glitch_pulses", np, 0);
    check("glitch_level_low_cycles", lowc, 0);
    KEY = 2'b11;
    repeat (20) step();

    // Bounce every 3 cycles
    p0 = 0; hic = 0;
    for (int i = 0; i < 45; i++) begin
      KEY[0] = (i >= 30) ? 1'b1 : (((i / 3) % 2) == 1);
      step();
      p0 += key_press[0];
      hic += key_level[0];
    end
    check("bounce_press", p0, 0);
    check("bounce_level_high_cycles", hic, 0);

    // Simultaneous press
    KEY = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) check("simul_level_at10", key_level, 2'b00);
      if (i == 11) check("simul_press_at11", key_press, 2'b11);
    end

    // Reset mid-press: no release pulse, then re-qualification
    r1 = 0;
    rst = 1'b1;
    step();
    check("midrst_outputs1", {key_level, key_press, key_release}, 0);
    step();
    check("midrst_outputs2", {key_level, key_press, key_release}, 0);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      r1 += key_release[1];
      if (i == 10) check("midrst_press1_at10", key_press[1], 0);
      if (i == 11) check("midrst_press1_at11", key_press[1], 1);
    end
    check("midrst_release1_count", r1, 0);

    // Long hold
    KEY = 2'b11;
    repeat (20) step();
    KEY = 2'b10;
    p0 = 0; r0 = 0; lowc = 0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      p0 += key_press[0];
      r0 += key_release[0];
      if (i >= 11 && key_level[0] == 1'b0) lowc++;
    end
    check("hold_press_count", p0, 1);
    check("hold_release_count", r0, 0);
    check("hold_level_low_cycles", lowc, 0);
    KEY = 2'b11;
    repeat (20) step();

    // Random segments checked by the reference model
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
      end
      KEY = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 20)) step();
    end
    KEY = 2'b11;
    repeat (20) step();
    check("final_level", key_level, 2'b00);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
